// File: rtl/preta_tile_buffer.sv
// Ping-pong tile buffer: packs a backpressure-free sample stream into TILE-sample
// tiles in two banks and hands each full or flushed tile to the transform.
module preta_tile_buffer #(
  parameter int DATA_W = 16,
  parameter int TILE   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     flush,
  input  logic                     tile_ready,
  input  logic                     clear_ovf,
  output logic                     tile_valid,
  output logic [TILE*DATA_W-1:0]   tile_data,
  output logic [$clog2(TILE):0]    tile_len,
  output logic [1:0]               occupancy,
  output logic                     overflow
);
  localparam int FW = $clog2(TILE);
  localparam int LW = FW + 1;

  logic [TILE-1:0][DATA_W-1:0] bank [2];
  logic [LW-1:0]               len  [2];
  logic [1:0]                  full;
  logic                        wb, rb;
  logic [FW-1:0]               fc;
  logic                        ovf;

  logic          pop, wb_free, wr, drop, complete, flush_do;
  logic [LW-1:0] fill;

  // When both banks are full wb==rb, so a same-cycle pop frees the write bank.
  assign pop      = full[rb] & tile_ready;
  assign wb_free  = ~full[wb] | (pop & (rb == wb));
  assign wr       = valid_in & wb_free;
  assign drop     = valid_in & ~wb_free;
  assign fill     = {1'b0, fc} + LW'(wr);
  assign complete = wr & (fc == FW'(TILE - 1));
  assign flush_do = flush & wb_free & ~complete & (fill != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank[b] <= '0;
        len[b]  <= '0;
      end
      full <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      fc   <= '0;
      ovf  <= 1'b0;
    end else begin
      if (pop) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
      if (wr)
        bank[wb][fc] <= data_in;
      if (complete) begin
        full[wb] <= 1'b1;
        len[wb]  <= LW'(TILE);
        wb       <= ~wb;
        fc       <= '0;
      end else if (flush_do) begin
        full[wb] <= 1'b1;
        len[wb]  <= fill;
        wb       <= ~wb;
        fc       <= '0;
        // stale samples from the previous tile in this bank must not leak out
        for (int i = 0; i < TILE; i++)
          if (LW'(i) >= fill)
            bank[wb][i] <= '0;
      end else if (wr) begin
        fc <= fc + FW'(1);
      end
      if (drop)
        ovf <= 1'b1;
      else if (clear_ovf)
        ovf <= 1'b0;
    end
  end

  assign tile_valid = full[rb];
  assign tile_data  = bank[rb];
  assign tile_len   = len[rb];
  assign occupancy  = {1'b0, full[0]} + {1'b0, full[1]};
  assign overflow   = ovf;

endmodule
